// File: rtl/accel_bcd_sched.sv
// accel_bcd_sched: once per frame, converts the X/Y/Z accelerometer values to
// hundreds/tens/ones BCD digits. One shared shift-add-3 engine handles the
// three channels in turn. All nine digits and the overflow flags are
// committed to the outputs on a single edge.
module accel_bcd_sched #(
    parameter int unsigned DW        = 16,
    parameter logic        VS_ACTIVE = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vga_vs,
    input  logic [DW-1:0] data_x,
    input  logic [DW-1:0] data_y,
    input  logic [DW-1:0] data_z,
    output logic [3:0]    x_hund,
    output logic [3:0]    x_tens,
    output logic [3:0]    x_ones,
    output logic [3:0]    y_hund,
    output logic [3:0]    y_tens,
    output logic [3:0]    y_ones,
    output logic [3:0]    z_hund,
    output logic [3:0]    z_tens,
    output logic [3:0]    z_ones,
    output logic [2:0]    ovf,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_STORE,
        S_COMMIT
    } state_t;

    state_t        state_q, state_d;
    logic          vs_q;
    logic          start;
    logic [DW-1:0] snap_x_q, snap_y_q, snap_z_q;
    logic [1:0]    ch_q;
    logic [3:0]    cnt_q;
    logic [9:0]    bin_q;
    logic [11:0]   bcd_q;
    logic [11:0]   stg_x_q, stg_y_q, stg_z_q;
    logic [2:0]    stg_ovf_q;
    logic [11:0]   out_x_q, out_y_q, out_z_q;
    logic [2:0]    ovf_q;
    logic          done_q;
    logic [DW-1:0] cur_snap;
    logic          cur_ovf;
    logic [9:0]    cur_clamped;
    logic [11:0]   bcd_adj;

    // A conversion starts on the first cycle of the active sync level.
    assign start = (vga_vs == VS_ACTIVE) && (vs_q != VS_ACTIVE);

    // Register the previous sync level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vs_q <= ~VS_ACTIVE;
        else        vs_q <= vga_vs;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: three channels of LOAD/SHIFTx10/STORE, then COMMIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD;
            S_LOAD:   state_d = S_SHIFT;
            S_SHIFT:  if (cnt_q == 4'd9) state_d = S_STORE;
            S_STORE:  state_d = (ch_q == 2'd2) ? S_COMMIT : S_LOAD;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Select the snapshot of the current channel and clamp it to 999.
    always_comb begin
        case (ch_q)
            2'd0:    cur_snap = snap_x_q;
            2'd1:    cur_snap = snap_y_q;
            default: cur_snap = snap_z_q;
        endcase
        cur_ovf     = (cur_snap >= DW'(1000));
        cur_clamped = cur_ovf ? 10'd999 : cur_snap[9:0];
    end

    // Double-dabble correction: add 3 to every BCD nibble of 5 or more.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    // Datapath: snapshot, per-channel conversion, staging and commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_x_q  <= '0;
            snap_y_q  <= '0;
            snap_z_q  <= '0;
            ch_q      <= 2'd0;
            cnt_q     <= 4'd0;
            bin_q     <= 10'd0;
            bcd_q     <= 12'd0;
            stg_x_q   <= 12'd0;
            stg_y_q   <= 12'd0;
            stg_z_q   <= 12'd0;
            stg_ovf_q <= 3'b000;
            out_x_q   <= 12'd0;
            out_y_q   <= 12'd0;
            out_z_q   <= 12'd0;
            ovf_q     <= 3'b000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        snap_x_q <= data_x;
                        snap_y_q <= data_y;
                        snap_z_q <= data_z;
                        ch_q     <= 2'd0;
                    end
                end
                S_LOAD: begin
                    bin_q <= cur_clamped;
                    bcd_q <= 12'd0;
                    cnt_q <= 4'd0;
                    case (ch_q)
                        2'd0:    stg_ovf_q[0] <= cur_ovf;
                        2'd1:    stg_ovf_q[1] <= cur_ovf;
                        default: stg_ovf_q[2] <= cur_ovf;
                    endcase
                end
                S_SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    cnt_q          <= cnt_q + 4'd1;
                end
                S_STORE: begin
                    case (ch_q)
                        2'd0:    stg_x_q <= bcd_q;
                        2'd1:    stg_y_q <= bcd_q;
                        default: stg_z_q <= bcd_q;
                    endcase
                    if (ch_q != 2'd2) ch_q <= ch_q + 2'd1;
                end
                S_COMMIT: begin
                    out_x_q <= stg_x_q;
                    out_y_q <= stg_y_q;
                    out_z_q <= stg_z_q;
                    ovf_q   <= stg_ovf_q;
                end
                default: ;
            endcase
        end
    end

    // done marks the single cycle in which freshly committed digits appear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= (state_q == S_COMMIT);
    end

    // busy also spans the done cycle, so it drops one edge after the commit.
    assign busy = (state_q != S_IDLE) || done_q;
    assign done = done_q;
    assign ovf  = ovf_q;

    assign {x_hund, x_tens, x_ones} = out_x_q;
    assign {y_hund, y_tens, y_ones} = out_y_q;
    assign {z_hund, z_tens, z_ones} = out_z_q;

endmodule

// File: tb/tb_accel_bcd_sched.sv
// tb_accel_bcd_sched: directed and random frames for accel_bcd_sched.
// A reference model uses plain decimal arithmetic. Each sync edge it accepts
// queues an expected commit that is due 37 edges after the start edge.
module tb_accel_bcd_sched;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vga_vs;
    logic [DW-1:0] data_x, data_y, data_z;
    logic [3:0]    x_hund, x_tens, x_ones;
    logic [3:0]    y_hund, y_tens, y_ones;
    logic [3:0]    z_hund, z_tens, z_ones;
    logic [2:0]    ovf;
    logic          busy, done;
    logic [38:0]   obs_all;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic        model_vs_q;
    bit          model_active = 1'b0;
    int          acc_edge = 0;
    int          edge_no = 0;
    int          done_cnt = 0;
    logic [38:0] cur_val = '0;
    logic [38:0] exp_q[$];

    accel_bcd_sched #(.DW(DW), .VS_ACTIVE(1'b0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .vga_vs (vga_vs),
        .data_x (data_x),
        .data_y (data_y),
        .data_z (data_z),
        .x_hund (x_hund),
        .x_tens (x_tens),
        .x_ones (x_ones),
        .y_hund (y_hund),
        .y_tens (y_tens),
        .y_ones (y_ones),
        .z_hund (z_hund),
        .z_tens (z_tens),
        .z_ones (z_ones),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    assign obs_all = {ovf, x_hund, x_tens, x_ones, y_hund, y_tens, y_ones, z_hund, z_tens, z_ones};

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    function automatic logic [11:0] digits_of(input int unsigned v);
        int unsigned c;
        c = (v >= 1000) ? 999 : v;
        return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [38:0] ref_result(input int unsigned x, input int unsigned y,
                                               input int unsigned z);
        return {(z >= 1000), (y >= 1000), (x >= 1000), digits_of(x), digits_of(y), digits_of(z)};
    endfunction

    function automatic int unsigned rand_val();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 999);
            1:       return $urandom_range(990, 1010);
            2:       return $urandom_range(0, 65535);
            default: return $urandom_range(0, 20);
        endcase
    endfunction

    task automatic model_clear();
        model_vs_q   = 1'b1;
        model_active = 1'b0;
        exp_q.delete();
        cur_val      = '0;
    endtask

    // Driver tasks (all drive on the falling edge)
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_data(input int unsigned x, input int unsigned y, input int unsigned z);
        data_x = x[DW-1:0];
        data_y = y[DW-1:0];
        data_z = z[DW-1:0];
    endtask

    task automatic vs_pulse(input int low_len);
        vga_vs = 1'b0;
        tick(low_len);
        vga_vs = 1'b1;
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("rst_digits", obs_all, 39'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge clk);
        tick(cycles - 1);
        rst_n = 1'b1;
    endtask

    // Scoreboard: model acceptance on each rising edge, then check outputs
    initial begin
        forever begin
            @(posedge clk);
            edge_no++;
            if (rst_n === 1'b1) begin
                if (vga_vs == 1'b0 && model_vs_q == 1'b1 && !model_active) begin
                    model_active = 1'b1;
                    acc_edge     = edge_no;
                    exp_q.push_back(ref_result(data_x, data_y, data_z));
                end
                model_vs_q = vga_vs;
            end else begin
                model_clear();
            end
            #1;
            if (done === 1'b1) done_cnt++;
            if (model_active && edge_no == acc_edge + 37) begin
                check("done_at_commit", done, 1'b1);
                check("busy_at_commit", busy, 1'b1);
                if (exp_q.size() > 0) cur_val = exp_q.pop_front();
                model_active = 1'b0;
            end else begin
                check("done_quiet", done, 1'b0);
                check("busy", busy, model_active);
            end
            check("digits", obs_all, cur_val);
        end
    end

    // Stimulus
    initial begin
        int dc0;
        rst_n  = 1'b0;
        vga_vs = 1'b1;
        set_data($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535));
        model_clear();
        @(negedge clk);
        apply_reset(4);
        tick(5);

        // Basic conversion
        set_data(123, 45, 7);
        vs_pulse(2);
        tick(40);
        check("basic_x", obs_all[35:24], 12'h123);
        check("basic_y", obs_all[23:12], 12'h045);
        check("basic_z", obs_all[11:0], 12'h007);
        check("basic_ovf", ovf, 3'b000);

        // Overflow clamp
        set_data(999, 1000, 65535);
        vs_pulse(1);
        tick(40);
        check("ovf_digits", obs_all[35:0], 36'h999999999);
        check("ovf_flags", ovf, 3'b110);

        // Snapshot held; second sync during conversion ignored
        dc0 = done_cnt;
        set_data(321, 0, 0);
        vs_pulse(1);
        tick(3);
        data_x = 16'd654;
        tick(15);
        vs_pulse(1);
        tick(25);
        check("snap_x", obs_all[35:24], 12'h321);
        check("snap_one_done", done_cnt - dc0, 1);

        // Frame with a sync edge landing on the commit cycle (ignored)
        set_data(10, 0, 0);
        vs_pulse(1);
        tick(36);
        vs_pulse(1);
        tick(40);
        check("b2b_first", obs_all[35:24], 12'h010);
        set_data(11, 0, 0);
        vs_pulse(1);
        tick(40);
        check("b2b_second", obs_all[35:24], 12'h011);

        // Sync edge on the first idle cycle after commit is accepted
        set_data(21, 0, 0);
        vs_pulse(1);
        tick(37);
        data_x = 16'd22;
        vs_pulse(1);
        tick(40);
        check("edge39_x", obs_all[35:24], 12'h022);

        // Reset in the middle of a conversion
        set_data(500, 0, 0);
        vs_pulse(1);
        tick(18);
        apply_reset(3);
        tick(2);
        vs_pulse(1);
        tick(40);
        check("post_rst_x", obs_all[35:24], 12'h500);

        // Random frames with random sync spacing
        for (int i = 0; i < 60; i++) begin
            set_data(rand_val(), rand_val(), rand_val());
            vs_pulse($urandom_range(1, 3));
            tick($urandom_range(5, 50));
        end
        vga_vs = 1'b1;
        tick(45);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
